icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_W, default 6, log2 of line count (64 direct-mapped lines of 16 bytes).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rdy  input  1  global ready; low freezes all state and outputs.
REQ-005 if_valid  input  1  fetch request from IF, held until if_done.
REQ-006 if_pc  input  32  fetch address, word-aligned, stable while if_valid.
REQ-007 if_flush  input  1  pipeline flush (mispredict), one-cycle pulse.
REQ-008 if_done  output  1  one-cycle pulse, if_inst valid.
REQ-009 if_inst  output  32  fetched instruction word.
REQ-010 fc_valid  output  1  line-fetch request to memctrl.
REQ-011 fc_addr  output  32  line-aligned fetch address, low 4 bits zero.
REQ-012 fc_done  input  1  one-cycle pulse from memctrl, fc_line valid.
REQ-013 fc_line  input  128  refill line, byte 0 in bits 7:0.

Function
REQ-014 Address split: offset pc[3:0], word select pc[3:2], index pc[4+INDEX_W-1:4], tag pc[31:4+INDEX_W].
REQ-015 Per line: valid bit, tag, 128-bit data; word k = data[32k+31:32k].
REQ-016 States: IDLE, MISS, REFILL.
REQ-017 IDLE, if_valid high, if_done low: lookup; valid and tag match -> hit, if_done pulse next cycle with selected word, stay IDLE.
REQ-018 IDLE miss: next cycle fc_valid=1, fc_addr={pc[31:4],4'b0}, go MISS.
REQ-019 MISS: fc_valid and fc_addr held stable until fc_done sampled high.
REQ-020 fc_done in MISS: write line, set valid, store tag, drop fc_valid next cycle, go REFILL.
REQ-021 REFILL: pulse if_done with requested word from newly written line, return IDLE; miss latency = memctrl latency + 2 cycles.
REQ-022 No request accepted in the cycle if_done is high (IF still shows old request).
REQ-023 if_flush in IDLE: pending lookup dropped, no if_done that cycle or next.
REQ-024 if_flush in MISS/REFILL: memctrl fetch not aborted; line still written on fc_done; if_done suppressed; return IDLE.
REQ-025 fc_done outside MISS ignored, cache unchanged.
REQ-026 rdy low: no state, array or output change; pulses stretch until rdy returns.
REQ-027 At most one outstanding memctrl request.

Reset
REQ-028 rst clears all valid bits, state IDLE, if_done=0, if_inst=0, fc_valid=0, fc_addr=0, counters 0.
REQ-029 rst mid-MISS: fc_valid low next cycle; later fc_done ignored per REQ-025.
REQ-030 Data/tag arrays need no reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN: defined -> outputs stat_hit and stat_miss (32-bit each) count accepted hits and misses, wrapping at 2^32, cleared by rst, frozen when rdy low; undefined -> ports absent, no counter logic.

Structure
REQ-032 ADDR_TP, WORD_TP, LINE_TP widths, TRUE/FALSE and ZERO constants from shared utils header; state encodings local.
REQ-033 Optional sub-module icache_array: valid/tag/data storage, one read and one write port.

Verification
REQ-034 Cold miss: reset, if_pc=0x1004 -> fc_valid, fc_addr=0x1000; fc_line word1=0xDEADBEEF -> if_done, if_inst=0xDEADBEEF.
REQ-035 Hit: then if_pc=0x100C -> if_done one cycle later, word3, no fc_valid.
REQ-036 Conflict: 0x1000 then 0x2000 (same index, INDEX_W=6, stride 0x400) -> second misses; re-fetch 0x1000 misses again.
REQ-037 Flush in MISS: flush before fc_done -> no if_done; next 0x1000 request hits.
REQ-038 rdy low 5 cycles across fc_done -> outputs frozen, response resumes intact.
REQ-039 ICACHE_STATS_EN: 3 hits, 2 misses -> stat_hit=3, stat_miss=2; rst clears both.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache.
package icache_pkg;

    typedef logic [31:0]  ADDR_TP;
    typedef logic [31:0]  WORD_TP;
    typedef logic [127:0] LINE_TP;

    localparam logic   TRUE  = 1'b1;
    localparam logic   FALSE = 1'b0;
    localparam ADDR_TP ZERO  = 32'd0;

    function automatic WORD_TP line_word(input LINE_TP line, input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port, one write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output LINE_TP             rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  LINE_TP             wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    LINE_TP           data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= TRUE;
        end
    end

    // Tag and data carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with single outstanding line refill.
// Define ICACHE_STATS_EN to add the stat_hit/stat_miss counters.
//
// state     | meaning
// ST_IDLE   | accept lookups; hit answers next cycle, miss issues refill
// ST_MISS   | fc_valid held until memctrl returns the line
// ST_REFILL | line written; return requested word unless flushed
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rdy,
    input  logic   if_valid,
    input  ADDR_TP if_pc,
    input  logic   if_flush,
    output logic   if_done,
    output WORD_TP if_inst,
    output logic   fc_valid,
    output ADDR_TP fc_addr,
    input  logic   fc_done,
    input  LINE_TP fc_line
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss
`endif
);

    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {ST_IDLE, ST_MISS, ST_REFILL} state_t;

    state_t             state_q, state_d;
    logic               if_done_d, fc_valid_d;
    WORD_TP             if_inst_d;
    ADDR_TP             fc_addr_d;
    logic               flushed_q, flushed_d;
    logic [1:0]         req_word_q, req_word_d;
    logic               wr_req, lookup, hit;
    logic [INDEX_W-1:0] rd_index;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    LINE_TP             rd_data;
    logic               pc_unused;

    assign pc_unused = ^if_pc[1:0];

    // During refill the array is read back at the line just written.
    assign rd_index = (state_q == ST_REFILL) ? fc_addr[4 +: INDEX_W] : if_pc[4 +: INDEX_W];
    assign lookup   = (state_q == ST_IDLE) && if_valid && !if_done && !if_flush;
    assign hit      = rd_valid && (rd_tag == if_pc[31 -: TAG_W]);

    icache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_req && rdy),
        .wr_index (fc_addr[4 +: INDEX_W]),
        .wr_tag   (fc_addr[31 -: TAG_W]),
        .wr_data  (fc_line)
    );

    always_comb begin
        state_d    = state_q;
        if_done_d  = FALSE;
        if_inst_d  = if_inst;
        fc_valid_d = fc_valid;
        fc_addr_d  = fc_addr;
        flushed_d  = flushed_q;
        req_word_d = req_word_q;
        wr_req     = FALSE;
        case (state_q)
            ST_IDLE: begin
                flushed_d = FALSE;
                if (lookup) begin
                    if (hit) begin
                        if_done_d = TRUE;
                        if_inst_d = line_word(rd_data, if_pc[3:2]);
                    end else begin
                        fc_valid_d = TRUE;
                        fc_addr_d  = {if_pc[31:4], 4'b0};
                        req_word_d = if_pc[3:2];
                        state_d    = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (if_flush) flushed_d = TRUE;
                if (fc_done) begin
                    wr_req     = TRUE;
                    fc_valid_d = FALSE;
                    state_d    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                state_d   = ST_IDLE;
                flushed_d = FALSE;
                if (!flushed_q && !if_flush) begin
                    if_done_d = TRUE;
                    if_inst_d = line_word(rd_data, req_word_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            if_done    <= FALSE;
            if_inst    <= ZERO;
            fc_valid   <= FALSE;
            fc_addr    <= ZERO;
            flushed_q  <= FALSE;
            req_word_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            if_done    <= if_done_d;
            if_inst    <= if_inst_d;
            fc_valid   <= fc_valid_d;
            fc_addr    <= fc_addr_d;
            flushed_q  <= flushed_d;
            req_word_q <= req_word_d;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit  <= ZERO;
            stat_miss <= ZERO;
        end else if (rdy && lookup) begin
            if (hit) stat_hit  <= stat_hit + 32'd1;
            else     stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule
